// File: rtl/next_pc_unit.sv
// next_pc_unit: next-address generator for the single-cycle fetch path.
// Each cycle it picks the PC load value: reset (0), hold, return, jump/call,
// taken branch or sequential. Calls and returns go through a return-address
// store, so nested jal / jr $ra resolve without reading the register file.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pc_in               current PC
//   stall               hold PC, no return-address store change
//   branch_taken        take branch to pc_in + 1 + branch_offset (signed)
//   jump, call, ret     jump, jal (push pc_in + 1), jr $ra (pop)
//   jump_target         absolute target for jump and call
//   next_pc             selected address (combinational)
//   ras_empty/ras_full  store occupancy, decoded from registered count
//   ras_err             sticky overflow/underflow flag, cleared by reset
//
// Configuration macro NEXT_PC_RAS_EN:
//   defined   - DEPTH-entry circular return-address stack
//   undefined - single link register (DEPTH only sizes the count register)
module next_pc_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] pc_in,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [4:0] branch_offset,
    input  logic       jump,
    input  logic       call,
    input  logic       ret,
    input  logic [4:0] jump_target,
    output logic [4:0] next_pc,
    output logic       ras_empty,
    output logic       ras_full,
    output logic       ras_err
);

    localparam int unsigned PC_W  = 5;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef NEXT_PC_RAS_EN
    localparam int unsigned CAP   = DEPTH;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`else
    localparam int unsigned CAP   = 1;
`endif

    logic [PC_W-1:0]  seq;
    logic [PC_W-1:0]  br;
    logic [PC_W-1:0]  top;
    logic             do_ret;
    logic             do_call;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Same-width add is the sign-extended add with the carry dropped.
    assign seq = pc_in + PC_W'(1);
    assign br  = seq + branch_offset;

    // Stack operations this edge; ret beats call, stall and reset kill both.
    assign do_ret  = !reset && !stall && ret;
    assign do_call = !reset && !stall && call && !ret;

`ifdef NEXT_PC_RAS_EN
    logic [PC_W-1:0]  stack_q [DEPTH];
    logic [PTR_W-1:0] wp_q;
    logic [PTR_W-1:0] top_idx;

    assign top_idx = wp_q - PTR_W'(1);
    assign top     = stack_q[top_idx];

    // Circular stack; a push when full overwrites the oldest entry at wp.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            wp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (do_ret) begin
            if (cnt_q != '0) begin
                wp_q  <= top_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                err_q <= 1'b1;
            end
        end else if (do_call) begin
            stack_q[wp_q] <= seq;
            wp_q          <= wp_q + PTR_W'(1);
            if (cnt_q == CNT_W'(CAP)) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    logic [PC_W-1:0] link_q;

    assign top = link_q;

    // Single link register; count is 0 or 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            link_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (do_ret) begin
            if (cnt_q != '0) begin
                cnt_q <= '0;
            end else begin
                err_q <= 1'b1;
            end
        end else if (do_call) begin
            link_q <= seq;
            if (cnt_q == CNT_W'(CAP)) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= CNT_W'(1);
            end
        end
    end
`endif

    // Priority select of the next PC.
    always_comb begin
        next_pc = seq;
        if (reset) begin
            next_pc = '0;
        end else if (stall) begin
            next_pc = pc_in;
        end else if (ret) begin
            next_pc = (cnt_q != '0) ? top : seq;
        end else if (call || jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = br;
        end
    end

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(CAP));
    assign ras_err   = err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: constant vector table, hand-written call/return
// sequences and random traffic, all checked against a queue-based model.
module tb_next_pc_unit;

    localparam int unsigned DEPTH = 4;
`ifdef NEXT_PC_RAS_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset, stall, branch_taken, jump, call, ret;
    logic [4:0] pc_in, branch_offset, jump_target;
    logic [4:0] next_pc;
    logic       ras_empty, ras_full, ras_err;

    next_pc_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
        .next_pc(next_pc), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: return addresses in a queue, newest at the back.
    logic [4:0] m_q[$];
    logic       m_err;

    typedef struct {
        logic       rst, st, bt, jp, cl, rt;
        logic [4:0] pc, off, tgt;
        logic [4:0] exp_pc;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply one cycle, check combinational result and flags, then clock it.
    task automatic step(input logic rst, st, bt, jp, cl, rt,
                        input logic [4:0] pc, off, tgt, output logic [4:0] got);
        logic [4:0] seq, exp;
        reset = rst; stall = st; branch_taken = bt; jump = jp; call = cl; ret = rt;
        pc_in = pc; branch_offset = off; jump_target = tgt;
        #1;
        seq = pc + 5'd1;
        if (rst)                 exp = 5'd0;
        else if (st)             exp = pc;
        else if (rt)             exp = (m_q.size() > 0) ? m_q[$] : seq;
        else if (cl || jp)       exp = tgt;
        else if (bt)             exp = 5'(pc + 5'd1 + off);
        else                     exp = seq;
        got = next_pc;
        chk("next_pc", 32'(next_pc), 32'(exp));
        chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
        chk("ras_full", 32'(ras_full), 32'(m_q.size() == CAP));
        chk("ras_err", 32'(ras_err), 32'(m_err));
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_err = 1'b0;
        end else if (!st && rt) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_err = 1'b1;
        end else if (!st && cl) begin
            if (m_q.size() == CAP) begin
                void'(m_q.pop_front());
                m_err = 1'b1;
            end
            m_q.push_back(seq);
        end
        #1;
    endtask

    task automatic do_reset();
        logic [4:0] g;
        step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, g);
    endtask

    initial begin
        logic [4:0] g;
        logic [4:0] exp_rets [5];

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 5'd31, 5'd0,  5'd0,  5'd0};
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 5'd3,  5'b11100, 5'd0, 5'd0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 5'd30, 5'd3,  5'd0,  5'd2};
        tbl[3]  = '{0, 1, 0, 0, 1, 1, 5'd7,  5'd0,  5'd0,  5'd7};
        tbl[4]  = '{0, 0, 0, 1, 0, 0, 5'd5,  5'd0,  5'd17, 5'd17};
        tbl[5]  = '{0, 0, 1, 1, 0, 0, 5'd5,  5'd1,  5'd9,  5'd9};
        tbl[6]  = '{0, 0, 1, 0, 0, 0, 5'd0,  5'd15, 5'd0,  5'd16};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 5'd20, 5'd16, 5'd0,  5'd5};
        tbl[8]  = '{0, 1, 1, 0, 0, 0, 5'd4,  5'd1,  5'd0,  5'd4};
        tbl[9]  = '{1, 0, 0, 1, 0, 0, 5'd12, 5'd0,  5'd3,  5'd0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 5'd9,  5'd0,  5'd0,  5'd10};

        m_err = 1'b0;
        reset = 1'b1; stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
        pc_in = 5'd0; branch_offset = 5'd0; jump_target = 5'd0;
        #1;
        chk("reset_next_pc", 32'(next_pc), 32'd0);
        @(posedge clk);
        #1;
        m_q.delete();

        // Vector table from the empty state.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].bt, tbl[i].jp, tbl[i].cl, tbl[i].rt,
                 tbl[i].pc, tbl[i].off, tbl[i].tgt, g);
            chk($sformatf("tbl%0d", i), 32'(g), 32'(tbl[i].exp_pc));
        end
        // Underflow from the last vector stays sticky.
        step(0, 0, 0, 0, 0, 0, 5'd1, 5'd0, 5'd0, g);
        chk("underflow_sticky", 32'(ras_err), 32'd1);

        // Nested call/return.
        do_reset();
        chk("post_reset_empty", 32'(ras_empty), 32'd1);
        chk("post_reset_err", 32'(ras_err), 32'd0);
        step(0, 0, 0, 0, 1, 0, 5'd2,  5'd0, 5'd10, g);
        step(0, 0, 0, 0, 1, 0, 5'd10, 5'd0, 5'd20, g);
        step(0, 0, 0, 0, 0, 1, 5'd20, 5'd0, 5'd0, g);
        chk("nest_ret1", 32'(g), 32'd11);
        step(0, 0, 0, 0, 0, 1, 5'd11, 5'd0, 5'd0, g);
`ifdef NEXT_PC_RAS_EN
        chk("nest_ret2", 32'(g), 32'd3);
        chk("nest_err", 32'(ras_err), 32'd0);
`else
        chk("nest_ret2", 32'(g), 32'd12);
        chk("nest_err", 32'(ras_err), 32'd1);
`endif
        chk("nest_empty", 32'(ras_empty), 32'd1);

        // Overflow: five calls, then five returns.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0, 5'(i), 5'd0, 5'(8 + i), g);
            if (i == 3) chk("ovf_full", 32'(ras_full), 32'd1);
        end
        chk("ovf_err", 32'(ras_err), 32'd1);
`ifdef NEXT_PC_RAS_EN
        exp_rets = '{5'd5, 5'd4, 5'd3, 5'd2, 5'd21};
`else
        exp_rets = '{5'd5, 5'd21, 5'd21, 5'd21, 5'd21};
`endif
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 1, 5'd20, 5'd0, 5'd0, g);
            chk($sformatf("ovf_ret%0d", i), 32'(g), 32'(exp_rets[i]));
        end
        chk("ovf_empty", 32'(ras_empty), 32'd1);

        // Stall suppresses push/pop; call+ret pops without pushing.
        do_reset();
        step(0, 0, 0, 0, 1, 0, 5'd2, 5'd0, 5'd10, g);
        step(0, 1, 0, 0, 1, 1, 5'd7, 5'd0, 5'd25, g);
        chk("stall_pc", 32'(g), 32'd7);
        step(0, 0, 0, 0, 1, 1, 5'd7, 5'd0, 5'd25, g);
        chk("callret_pc", 32'(g), 32'd3);
        chk("callret_nopush", 32'(ras_empty), 32'd1);

        // Underflow sticky until reset.
        do_reset();
        step(0, 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd0, g);
        chk("uflow_pc", 32'(g), 32'd10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 5'd1, 5'd0, 5'd4, g);
        chk("uflow_hold", 32'(ras_err), 32'd1);
        do_reset();
        chk("uflow_clear", 32'(ras_err), 32'd0);

        // Reset mid call chain discards the stack.
        step(0, 0, 0, 0, 1, 0, 5'd1, 5'd0, 5'd6, g);
        step(1, 0, 0, 0, 1, 0, 5'd6, 5'd0, 5'd9, g);
        chk("midreset_pc", 32'(g), 32'd0);
        chk("midreset_empty", 32'(ras_empty), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 5'($urandom), 5'($urandom), 5'($urandom), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
